// File: rtl/ex_pkg.sv
// Shared opcode, result-class and divider-state definitions for the execute stage.
package ex_pkg;

    localparam logic [7:0] ALUOP_NOP  = 8'h00;
    localparam logic [7:0] ALUOP_OR   = 8'h25;
    localparam logic [7:0] ALUOP_AND  = 8'h24;
    localparam logic [7:0] ALUOP_XOR  = 8'h26;
    localparam logic [7:0] ALUOP_NOR  = 8'h27;
    localparam logic [7:0] ALUOP_SLL  = 8'h7C;
    localparam logic [7:0] ALUOP_SRL  = 8'h02;
    localparam logic [7:0] ALUOP_SRA  = 8'h03;
    localparam logic [7:0] ALUOP_ADDU = 8'h21;
    localparam logic [7:0] ALUOP_SUBU = 8'h23;
    localparam logic [7:0] ALUOP_SLT  = 8'h2A;
    localparam logic [7:0] ALUOP_SLTU = 8'h2B;
    localparam logic [7:0] ALUOP_DIV  = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU = 8'h1B;
    localparam logic [7:0] ALUOP_MFHI = 8'h10;
    localparam logic [7:0] ALUOP_MFLO = 8'h12;

    localparam logic [2:0] ALUSEL_NOP   = 3'd0;
    localparam logic [2:0] ALUSEL_LOGIC = 3'd1;
    localparam logic [2:0] ALUSEL_SHIFT = 3'd2;
    localparam logic [2:0] ALUSEL_MOVE  = 3'd3;
    localparam logic [2:0] ALUSEL_ARITH = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} div_state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, sign-corrected results
// presented while done is high.
module div_unit
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [DATA_W:0]   rem_sh, diff;

    // Partial remainder shifted left, pulling in the next dividend bit from quo_q.
    assign rem_sh = {rem_q, quo_q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy = 1'b1;
                    if (divisor != '0) begin
                        quo_d     = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
                        dvs_d     = (signed_op && divisor[DATA_W-1]) ? -divisor : divisor;
                        rem_d     = '0;
                        neg_quo_d = signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        neg_rem_d = signed_op && dividend[DATA_W-1];
                        cnt_d     = '0;
                        state_d   = RUN;
                    end else begin
                        state_d = DZERO;
                    end
                end
            end
            RUN: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DZERO: begin
                // Raw results, no sign correction: quotient all-ones, remainder = dividend.
                busy      = 1'b1;
                quo_d     = '1;
                rem_d     = dividend;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            busy    = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, HI/LO registers and the stalling divider.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ex_aluop,
    input  logic [2:0]        ex_alusel,
    input  logic [DATA_W-1:0] ex_reg1,
    input  logic [DATA_W-1:0] ex_reg2,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic              flush,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_req
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] logic_res, shift_res, arith_res, move_res, alu_res;
    logic [DATA_W-1:0] div_quo, div_rem;
    logic [SH_W-1:0]   shamt;
    logic              is_div, div_busy, div_done;

    assign is_div = is_div_op(ex_aluop);
    assign shamt  = ex_reg1[SH_W-1:0];

    div_unit #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (is_div),
        .signed_op(ex_aluop == ALUOP_DIV),
        .dividend (ex_reg1),
        .divisor  (ex_reg2),
        .flush    (flush),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_done) begin
            hi_q <= div_rem;
            lo_q <= div_quo;
        end
    end

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (ex_aluop)
            ALUOP_OR:   logic_res = ex_reg1 | ex_reg2;
            ALUOP_AND:  logic_res = ex_reg1 & ex_reg2;
            ALUOP_XOR:  logic_res = ex_reg1 ^ ex_reg2;
            ALUOP_NOR:  logic_res = ~(ex_reg1 | ex_reg2);
            default:    logic_res = '0;
        endcase
        case (ex_aluop)
            ALUOP_SLL:  shift_res = ex_reg2 << shamt;
            ALUOP_SRL:  shift_res = ex_reg2 >> shamt;
            ALUOP_SRA:  shift_res = $signed(ex_reg2) >>> shamt;
            default:    shift_res = '0;
        endcase
        case (ex_aluop)
            ALUOP_ADDU: arith_res = ex_reg1 + ex_reg2;
            ALUOP_SUBU: arith_res = ex_reg1 - ex_reg2;
            ALUOP_SLT:  arith_res = {{(DATA_W-1){1'b0}}, $signed(ex_reg1) < $signed(ex_reg2)};
            ALUOP_SLTU: arith_res = {{(DATA_W-1){1'b0}}, ex_reg1 < ex_reg2};
            default:    arith_res = '0;
        endcase
        case (ex_aluop)
            ALUOP_MFHI: move_res = hi_q;
            ALUOP_MFLO: move_res = lo_q;
            default:    move_res = '0;
        endcase
        case (ex_alusel)
            ALUSEL_LOGIC: alu_res = logic_res;
            ALUSEL_SHIFT: alu_res = shift_res;
            ALUSEL_ARITH: alu_res = arith_res;
            ALUSEL_MOVE:  alu_res = move_res;
            default:      alu_res = '0;
        endcase
    end

    always_comb begin
        wd_o      = ex_wd;
        wreg_o    = ex_wreg && !is_div;
        wdata_o   = is_div ? '0 : alu_res;
        stall_req = div_busy;
        if (rst) begin
            wd_o      = '0;
            wreg_o    = 1'b0;
            wdata_o   = '0;
            stall_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and random ALU/divide traffic against a
// behavioural model of the execute-stage rules.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg, flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_stage #(
        .DATA_W(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_aluop (ex_aluop),
        .ex_alusel(ex_alusel),
        .ex_reg1  (ex_reg1),
        .ex_reg2  (ex_reg2),
        .ex_wd    (ex_wd),
        .ex_wreg  (ex_wreg),
        .flush    (flush),
        .wd_o     (wd_o),
        .wreg_o   (wreg_o),
        .wdata_o  (wdata_o),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            ALUOP_OR, ALUOP_AND, ALUOP_XOR, ALUOP_NOR:     return ALUSEL_LOGIC;
            ALUOP_SLL, ALUOP_SRL, ALUOP_SRA:               return ALUSEL_SHIFT;
            ALUOP_ADDU, ALUOP_SUBU, ALUOP_SLT, ALUOP_SLTU: return ALUSEL_ARITH;
            ALUOP_MFHI, ALUOP_MFLO:                        return ALUSEL_MOVE;
            default:                                       return ALUSEL_NOP;
        endcase
    endfunction

    function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                              input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        if (sel == ALUSEL_NOP || sel != sel_of(op)) return 32'h0;
        case (op)
            ALUOP_OR:   return a | b;
            ALUOP_AND:  return a & b;
            ALUOP_XOR:  return a ^ b;
            ALUOP_NOR:  return ~(a | b);
            ALUOP_SLL:  return b * (32'h1 << sh);
            ALUOP_SRL:  return b / (33'h1 << sh);
            ALUOP_SRA:  return 32'(longint'($signed(b)) >>> sh);
            ALUOP_ADDU: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            ALUOP_SUBU: return 32'((longint'(a) - longint'(b)) & 64'hFFFF_FFFF);
            ALUOP_SLT:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            ALUOP_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALUOP_MFHI: return m_hi;
            ALUOP_MFLO: return m_lo;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic void model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [7:0] pick_op(input int unsigned i);
        case (i % 14)
            0:  return ALUOP_OR;
            1:  return ALUOP_AND;
            2:  return ALUOP_XOR;
            3:  return ALUOP_NOR;
            4:  return ALUOP_SLL;
            5:  return ALUOP_SRL;
            6:  return ALUOP_SRA;
            7:  return ALUOP_ADDU;
            8:  return ALUOP_SUBU;
            9:  return ALUOP_SLT;
            10: return ALUOP_SLTU;
            11: return ALUOP_MFHI;
            12: return ALUOP_MFLO;
            default: return ALUOP_NOP;
        endcase
    endfunction

    // Entered and left at posedge+1.
    task automatic alu_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string name);
        logic [4:0] wd;
        logic       w;
        wd = 5'($urandom);
        w  = 1'($urandom);
        ex_aluop = op; ex_alusel = sel; ex_reg1 = a; ex_reg2 = b; ex_wd = wd; ex_wreg = w;
        #1;
        n_cmp++;
        if (wdata_o !== exp) begin
            n_err++;
            $display("FAIL %s wdata: got %h expected %h", name, wdata_o, exp);
        end
        n_cmp++;
        if (wreg_o !== w || wd_o !== wd) begin
            n_err++;
            $display("FAIL %s wreg/wd: got %b/%0d expected %b/%0d", name, wreg_o, wd_o, w, wd);
        end
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s stall_req: got %b expected 0", name, stall_req);
        end
        @(posedge clk); #1;
    endtask

    // Runs one divide to completion, checks stall length and the HI/LO readback.
    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] q, r;
        int          cyc, exp_cyc;
        model_div(op == ALUOP_DIV, a, b, q, r);
        exp_cyc = (b == 32'h0) ? 2 : 33;
        ex_aluop = op; ex_alusel = ALUSEL_NOP; ex_reg1 = a; ex_reg2 = b;
        ex_wd = 5'd9; ex_wreg = 1'b1;
        #1;
        n_cmp++;
        if (wreg_o !== 1'b0 || wdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL %s div outputs: got wreg %b wdata %h expected 0/0", name, wreg_o, wdata_o);
        end
        cyc = 0;
        while (stall_req === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk); #2;
        end
        n_cmp++;
        if (cyc != exp_cyc) begin
            n_err++;
            $display("FAIL %s stall cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        n_cmp++;
        if (wreg_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s wreg in done: got %b expected 0", name, wreg_o);
        end
        @(posedge clk); #1;
        m_hi = r;
        m_lo = q;
        alu_op(ALUOP_MFLO, ALUSEL_MOVE, 32'h0, 32'h0, q, {name, " mflo"});
        alu_op(ALUOP_MFHI, ALUSEL_MOVE, 32'h0, 32'h0, r, {name, " mfhi"});
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        ex_aluop = ALUOP_OR; ex_alusel = ALUSEL_LOGIC; ex_reg1 = 32'hDEAD_BEEF;
        ex_reg2 = 32'h1234_5678; ex_wd = 5'd7; ex_wreg = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (wdata_o !== 32'h0 || wreg_o !== 1'b0 || wd_o !== 5'd0 || stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: got %h/%b/%0d/%b expected all zero",
                     wdata_o, wreg_o, wd_o, stall_req);
        end
        ex_aluop = ALUOP_DIV; ex_alusel = ALUSEL_NOP; ex_reg2 = 32'd3;
        #1;
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset div stall: got %b expected 0", stall_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ex_aluop = ALUOP_NOP;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        alu_op(ALUOP_MFHI, ALUSEL_MOVE, 32'h0, 32'h0, 32'h0, "reset hi");
        alu_op(ALUOP_MFLO, ALUSEL_MOVE, 32'h0, 32'h0, 32'h0, "reset lo");
    endtask

    task automatic test_logic_arith();
        alu_op(ALUOP_OR, ALUSEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or");
        alu_op(ALUOP_SUBU, ALUSEL_ARITH, 32'h0, 32'h1, 32'hFFFF_FFFF, "subu 0-1");
        alu_op(ALUOP_SLT, ALUSEL_ARITH, 32'hFFFF_FFFF, 32'h1, 32'h1, "slt -1<1");
        alu_op(ALUOP_SLTU, ALUSEL_ARITH, 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu -1<1");
        alu_op(8'hFF, ALUSEL_ARITH, 32'h5, 32'h6, 32'h0, "unknown op");
        alu_op(ALUOP_ADDU, ALUSEL_NOP, 32'h5, 32'h6, 32'h0, "alusel nop");
    endtask

    task automatic test_shifts();
        alu_op(ALUOP_SRA, ALUSEL_SHIFT, 32'd4, 32'h8000_0000, 32'hF800_0000, "sra 4");
        alu_op(ALUOP_SRL, ALUSEL_SHIFT, 32'd4, 32'h8000_0000, 32'h0800_0000, "srl 4");
        alu_op(ALUOP_SLL, ALUSEL_SHIFT, 32'd31, 32'h1, 32'h8000_0000, "sll 31");
    endtask

    task automatic test_random_alu();
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op  = pick_op($urandom);
            sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 4)) : sel_of(op);
            a   = $urandom;
            b   = $urandom;
            alu_op(op, sel, a, b, model_alu(op, sel, a, b), "random alu");
        end
    endtask

    task automatic test_div();
        do_div(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        n_cmp++;
        if (m_lo !== 32'hFFFF_FFFD || m_hi !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL div -7/2 model: got %h/%h expected fffffffd/ffffffff", m_lo, m_hi);
        end
        do_div(ALUOP_DIVU, 32'hFFFF_FFFF, 32'h10, "divu ffffffff/16");
        do_div(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div minint/-1");
        do_div(ALUOP_DIVU, 32'd7, 32'd0, "divu 7/0");
    endtask

    task automatic test_random_div();
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_div(($urandom_range(0, 1) == 1) ? ALUOP_DIV : ALUOP_DIVU, a, b, "random div");
        end
    endtask

    // Abort a divide at RUN cycle 10 by flush (abort_rst=0) or by reset (abort_rst=1).
    task automatic test_abort(input logic abort_rst, input string name);
        do_div(ALUOP_DIVU, 32'h5678_1234, 32'h0001_0000, {name, " preload"});
        ex_aluop = ALUOP_DIV; ex_alusel = ALUSEL_NOP;
        ex_reg1 = 32'd1000; ex_reg2 = 32'd7; ex_wreg = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        n_cmp++;
        if (stall_req !== 1'b1) begin
            n_err++;
            $display("FAIL %s pre-abort stall: got %b expected 1", name, stall_req);
        end
        if (abort_rst) rst = 1'b1;
        else flush = 1'b1;
        #1;
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s abort stall: got %b expected 0", name, stall_req);
        end
        @(posedge clk); #1;
        if (abort_rst) begin
            m_hi = '0;
            m_lo = '0;
        end
        rst = 1'b0; flush = 1'b0;
        ex_aluop = ALUOP_NOP;
        #1;
        n_cmp++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s post-abort stall: got %b expected 0", name, stall_req);
        end
        @(posedge clk); #1;
        alu_op(ALUOP_MFHI, ALUSEL_MOVE, 32'h0, 32'h0, abort_rst ? 32'h0 : 32'h1234, {name, " hi"});
        alu_op(ALUOP_MFLO, ALUSEL_MOVE, 32'h0, 32'h0, abort_rst ? 32'h0 : 32'h5678, {name, " lo"});
        do_div(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, {name, " rerun"});
    endtask

    task automatic test_back_to_back();
        do_div(ALUOP_DIVU, 32'd100, 32'd7, "b2b first");
        do_div(ALUOP_DIV, 32'd100, 32'hFFFF_FFF9, "b2b second");
        alu_op(ALUOP_ADDU, ALUSEL_ARITH, m_lo, m_hi, m_lo + m_hi, "b2b addu");
    endtask

    initial begin
        ex_aluop = ALUOP_NOP; ex_alusel = ALUSEL_NOP; ex_reg1 = '0; ex_reg2 = '0;
        ex_wd = '0; ex_wreg = 1'b0; flush = 1'b0; rst = 1'b1;
        test_reset();
        test_logic_arith();
        test_shifts();
        test_random_alu();
        test_div();
        test_random_div();
        test_abort(1'b0, "flush");
        test_abort(1'b1, "rst");
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Single-cycle ALU for logic, shift, add/sub and compare ops.
- Owns the HI/LO registers.
- Contains a 32-iteration restoring divider that stalls the pipeline via stall_req until the quotient and remainder are written to LO and HI.

Parameters:
- DATA_W, 32, operand/result width (divider iteration count = DATA_W).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_aluop  in  8  op code from ID/EX
- ex_alusel  in  3  result class from ID/EX
- ex_reg1  in  DATA_W  operand 1 (shamt in [4:0] for shifts; dividend for div)
- ex_reg2  in  DATA_W  operand 2 (shift source; divisor for div)
- ex_wd  in  5  destination register address
- ex_wreg  in  1  destination write enable
- flush  in  1  annul in-flight instruction/divide
- wd_o  out  5  destination to EX/MEM
- wreg_o  out  1  write enable to EX/MEM
- wdata_o  out  DATA_W  result to EX/MEM
- stall_req  out  1  hold PC/IF/ID/ID-EX this cycle

Behaviour:
Reset and output timing
- rst=1: hi_q=lo_q=0, FSM=IDLE, divider datapath cleared.
- wd_o, wreg_o, wdata_o and stall_req are combinational. They are forced to 0 while rst=1.

Non-div ops (0-cycle latency, stall_req=0)
- OR/AND/XOR/NOR: bitwise on reg1, reg2.
- SLL/SRL/SRA: reg2 shifted by reg1[4:0]. SRA replicates reg2[31].
- ADDU/SUBU: mod 2^32, no overflow trap.
- SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0.
- MFHI/MFLO: return hi_q/lo_q.
- Unknown op, or alusel=NOP: wdata_o=0.
- wdata_o is selected by alusel (LOGIC, SHIFT, ARITH, MOVE). wd_o=ex_wd. wreg_o=ex_wreg.

DIV/DIVU (wreg_o=0, wdata_o=0 throughout)
- Upstream holds ex_* constant while stall_req=1.
- IDLE: a div op is present and flush=0.
  - If divisor≠0: latch abs values (DIV) or raw values (DIVU) and sign flags. stall_req=1. Go to RUN with count=0.
  - If divisor=0: stall_req=1. Go to DZERO.
- RUN: one restoring step per cycle. stall_req=1. After count reaches DATA_W-1, go to DONE. This gives 32 RUN cycles.
- DZERO: stall_req=1. Go to DONE with quotient=all-ones, remainder=dividend.
- DONE: stall_req=0. At the clock edge, apply sign correction (DIV only: quotient negated if the signs differed; remainder takes the dividend's sign), then write lo_q←quotient and hi_q←remainder. Go to IDLE.
- Total stall: 33 cycles (divisor≠0) or 2 cycles (divisor=0).
- The next instruction's MFHI/MFLO sees the new values; no extra forwarding is needed.
- Edge cases:
  - flush=1 in any state: next state is IDLE, no HI/LO write, stall_req=0 that cycle.
  - rst mid-divide: same as reset; no HI/LO write.
  - MIN_INT / -1 (DIV): quotient=0x8000_0000, remainder=0, no trap.

Decomposition:
- Package ex_pkg holds:
  - aluop codes: NOP=00, OR=25, AND=24, XOR=26, NOR=27, SLL=7C, SRL=02, SRA=03, ADDU=21, SUBU=23, SLT=2A, SLTU=2B, DIV=1A, DIVU=1B, MFHI=10, MFLO=12 (hex).
  - alusel codes: NOP=0, LOGIC=1, SHIFT=2, MOVE=3, ARITH=4.
  - div_state_t enum {IDLE, RUN, DZERO, DONE}.
- Sub-module div_unit contains the FSM, iteration counter and restoring datapath.
  - Interface: start, signed_op, dividend, divisor, flush → busy, done, quotient, remainder.
  - ex_stage keeps the ALU mux and HI/LO.

Test Plan:
- Logic/arith sweep: OR 0xF0F0_0000|0x0000_0F0F → 0x F0F0_0F0F. SUBU 0-1 → 0xFFFF_FFFF. SLT(-1,1)=1, SLTU(-1,1)=0. All with stall_req=0 and wreg_o passed through.
- Shifts: SRA shamt=4 on 0x8000_0000 → 0xF800_0000. SRL → 0x0800_0000. SLL shamt=31 on 1 → 0x8000_0000.
- DIV -7/2: stall_req high exactly 33 cycles. Then lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). Following MFLO returns 0xFFFF_FFFD.
- DIVU 0xFFFF_FFFF/0x10 → lo=0x0FFF_FFFF, hi=0xF. DIV 0x8000_0000/-1 → lo=0x8000_0000, hi=0.
- Divide by zero (DIVU 7/0): stall 2 cycles → lo=0xFFFF_FFFF, hi=7.
- flush at RUN cycle 10, and separately rst at RUN cycle 10: stall_req drops, HI/LO unchanged (preloaded 0x1234/0x5678), and the next DIV runs the full 33 cycles correctly.
